// File: rtl/reg_display_writer.sv
// Renders a header, the instruction pointer and a bank of shadow registers as
// glyph requests to a letter writer, redrawing only strings marked dirty.
module reg_display_writer #(
  parameter int NUM_REGS     = 16,
  parameter int REG_WIDTH    = 16,
  parameter int IP_WIDTH     = 8,
  parameter int ROWS_PER_COL = 8,
  parameter int COL_X        = 450,
  parameter int ROW_Y        = 340,
  parameter int CHAR_W       = 7,
  parameter int ROW_H        = 12,
  parameter int COL_PITCH    = 80
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [3:0]           wr_idx,
  input  logic [REG_WIDTH-1:0] wr_data,
  input  logic [IP_WIDTH-1:0]  instr_ptr,
  input  logic                 force_redraw,
  output logic                 let_req,
  output logic [5:0]           let_code,
  output logic [9:0]           let_x,
  output logic [9:0]           let_y,
  input  logic                 let_ack,
  output logic                 busy
);

  localparam int NSTR   = NUM_REGS + 2;
  localparam int SEL_W  = $clog2(NSTR);
  localparam int SNAP_W = (REG_WIDTH > IP_WIDTH) ? REG_WIDTH : IP_WIDTH;
  localparam int GI_W   = 8;

  localparam logic [5:0] AN_E   = 6'd14;
  localparam logic [5:0] AN_G   = 6'd16;
  localparam logic [5:0] AN_I   = 6'd18;
  localparam logic [5:0] AN_P   = 6'd25;
  localparam logic [5:0] AN_R   = 6'd27;
  localparam logic [5:0] AN_S   = 6'd28;
  localparam logic [5:0] AN_T   = 6'd29;
  localparam logic [5:0] AN_DOT = 6'd36;
  localparam logic [5:0] AN_SP  = 6'd37;

  typedef enum logic [2:0] {IDLE, SCAN, LOAD, REQ, NEXT} state_t;

  state_t               state_q, state_d;
  logic [NSTR-1:0]      dirty_q, dirty_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [GI_W-1:0]      gidx_q, gidx_d;
  logic [SNAP_W-1:0]    snap_q, snap_d;
  logic [IP_WIDTH-1:0]  last_ip_q, last_ip_d;
  logic [REG_WIDTH-1:0] regs_q [NUM_REGS];
  logic [REG_WIDTH-1:0] regs_d [NUM_REGS];

  logic       any_dirty;
  logic       last_glyph;
  logic [5:0] code;
  logic [3:0] nib;
  int         gi, ndig, len_i, k_i, col_i, row_i;

  assign any_dirty = |dirty_q;

  // Shadow registers, dirty tracking and string snapshot.
  always_comb begin
    regs_d    = regs_q;
    dirty_d   = dirty_q;
    snap_d    = snap_q;
    last_ip_d = last_ip_q;
    if (state_q == LOAD) begin
      dirty_d[sel_q] = 1'b0;
      snap_d         = '0;
      if (sel_q == SEL_W'(1)) begin
        snap_d[IP_WIDTH-1:0] = instr_ptr;
        last_ip_d            = instr_ptr;
      end
      for (int k = 0; k < NUM_REGS; k++) begin
        if (sel_q == SEL_W'(k + 2)) snap_d[REG_WIDTH-1:0] = regs_q[k];
      end
    end
    for (int k = 0; k < NUM_REGS; k++) begin
      if (wr_en && (wr_idx == 4'(k))) begin
        regs_d[k]      = wr_data;
        dirty_d[k + 2] = 1'b1;
      end
    end
    // The IP being snapshotted this cycle is already what gets drawn.
    if ((instr_ptr != last_ip_q) && !((state_q == LOAD) && (sel_q == SEL_W'(1))))
      dirty_d[1] = 1'b1;
    if (force_redraw) dirty_d = '1;
  end

  // Glyph code and placement for the current string position.
  always_comb begin
    gi    = int'(gidx_q);
    code  = AN_DOT;
    nib   = 4'd0;
    ndig  = 0;
    len_i = 10;
    k_i   = 0;
    col_i = 0;
    row_i = 0;
    if (sel_q == '0) begin
      case (gi)
        0:       code = AN_R;
        1:       code = AN_E;
        2:       code = AN_G;
        3:       code = AN_I;
        4:       code = AN_S;
        5:       code = AN_T;
        6:       code = AN_E;
        7:       code = AN_R;
        8:       code = AN_S;
        default: code = AN_DOT;
      endcase
    end else begin
      if (sel_q == SEL_W'(1)) begin
        ndig  = IP_WIDTH / 4;
        col_i = 1;
      end else begin
        k_i   = int'(sel_q) - 2;
        ndig  = REG_WIDTH / 4;
        col_i = k_i / ROWS_PER_COL;
        row_i = 1 + (k_i % ROWS_PER_COL);
      end
      len_i = 4 + ndig;
      if (gi >= 4 && gi < len_i) nib = 4'(snap_q >> (4 * (len_i - 1 - gi)));
      case (gi)
        0:       code = (sel_q == SEL_W'(1)) ? AN_I : AN_R;
        1:       code = (sel_q == SEL_W'(1)) ? AN_P : 6'(k_i);
        2:       code = AN_DOT;
        3:       code = AN_SP;
        default: code = {2'b00, nib};
      endcase
    end
    last_glyph = (gi + 1 >= len_i);
    let_req  = (state_q == REQ);
    busy     = (state_q == LOAD) || (state_q == REQ) || (state_q == NEXT);
    let_code = '0;
    let_x    = '0;
    let_y    = '0;
    if (state_q == REQ) begin
      let_code = code;
      let_x    = 10'(COL_X + col_i * COL_PITCH + gi * CHAR_W);
      let_y    = 10'(ROW_Y + row_i * ROW_H);
    end
  end

  // Sequencer.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gidx_d  = gidx_q;
    case (state_q)
      IDLE: if (any_dirty) state_d = SCAN;
      SCAN: begin
        for (int i = NSTR - 1; i >= 0; i--) begin
          if (dirty_q[i]) sel_d = SEL_W'(i);
        end
        state_d = any_dirty ? LOAD : IDLE;
      end
      LOAD: begin
        gidx_d  = '0;
        state_d = REQ;
      end
      REQ:  if (let_ack) state_d = NEXT;
      NEXT: begin
        gidx_d = gidx_q + 1'b1;
        if (last_glyph) state_d = any_dirty ? SCAN : IDLE;
        else            state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dirty_q   <= '1;
      sel_q     <= '0;
      gidx_q    <= '0;
      snap_q    <= '0;
      last_ip_q <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      dirty_q   <= dirty_d;
      sel_q     <= sel_d;
      gidx_q    <= gidx_d;
      snap_q    <= snap_d;
      last_ip_q <= last_ip_d;
      regs_q    <= regs_d;
    end
  end

endmodule

// File: tb/tb_reg_display_writer.sv
// Scoreboard bench for reg_display_writer: a string-level model queues the
// expected glyphs, a monitor pops one per accepted request.
module tb_reg_display_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, force_redraw, let_ack;
  logic [3:0]  wr_idx;
  logic [15:0] wr_data;
  logic [7:0]  instr_ptr;
  logic        let_req, busy;
  logic [5:0]  let_code;
  logic [9:0]  let_x, let_y;

  logic        wr_en2, force_redraw2, let_ack2, let_req2, busy2;
  logic [3:0]  wr_idx2;
  logic [15:0] wr_data2;
  logic [5:0]  let_code2;
  logic [9:0]  let_x2, let_y2;

  always #5 clk = ~clk;

  reg_display_writer dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .instr_ptr(instr_ptr), .force_redraw(force_redraw), .let_req(let_req),
    .let_code(let_code), .let_x(let_x), .let_y(let_y), .let_ack(let_ack), .busy(busy)
  );

  reg_display_writer #(.NUM_REGS(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .wr_idx(wr_idx2), .wr_data(wr_data2),
    .instr_ptr(8'h00), .force_redraw(force_redraw2), .let_req(let_req2),
    .let_code(let_code2), .let_x(let_x2), .let_y(let_y2), .let_ack(let_ack2), .busy(busy2)
  );

  int          checks = 0;
  int          failures = 0;
  int          ack_mode = 0;
  logic [25:0] sb [$];
  logic [15:0] m_regs [16];
  logic [7:0]  m_ip;
  logic [17:0] dmask;
  logic        pr = 1'b0, pa = 1'b0;
  logic [25:0] pg = '0, mg, me, g0;
  int          t, lat, hi, quiet, total;
  logic [7:0]  nip;
  logic [3:0]  ridx;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected glyph sequence of string s (0 header, 1 IP, 2+k register k).
  task automatic push_str(input int s);
    int codes[$];
    int hdr[10] = '{27, 14, 16, 18, 28, 29, 14, 27, 28, 36};
    int col, row, nd, x, y;
    logic [31:0] v;
    col = 0; row = 0; nd = 0; v = 0;
    if (s == 0) begin
      foreach (hdr[i]) codes.push_back(hdr[i]);
    end else if (s == 1) begin
      codes.push_back(18); codes.push_back(25); codes.push_back(36); codes.push_back(37);
      nd = 2; v = 32'(m_ip); col = 1;
    end else begin
      codes.push_back(27); codes.push_back(s - 2); codes.push_back(36); codes.push_back(37);
      nd = 4; v = 32'(m_regs[s - 2]); col = (s - 2) / 8; row = 1 + (s - 2) % 8;
    end
    for (int j = 0; j < nd; j++) codes.push_back(int'((v >> (4 * (nd - 1 - j))) & 32'hf));
    for (int i = 0; i < codes.size(); i++) begin
      x = (450 + col * 80 + i * 7) % 1024;
      y = (340 + row * 12) % 1024;
      sb.push_back({6'(codes[i]), 10'(x), 10'(y)});
    end
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 20000) begin
      @(posedge clk);
      w++;
    end
    check(w < 20000, {name, "_drain"}, sb.size(), 0);
    if (w >= 20000) sb.delete();
    repeat (4) @(posedge clk);
    #2;
    check(!busy && !let_req, {name, "_idle"}, {busy, let_req}, 0);
  endtask

  initial begin
    let_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0:       let_ack = 1'($urandom % 2);
        1:       let_ack = 1'b1;
        default: let_ack = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      mg = {let_code, let_x, let_y};
      if (!rst_n) begin
        pr = 1'b0;
        pa = 1'b0;
      end else begin
        if (pa) check(!let_req, "req_gap", let_req, 0);
        else if (pr && let_req) check(mg == pg, "req_stable", mg, pg);
        if (let_req && let_ack) begin
          if (sb.size() == 0) check(1'b0, "unexpected_glyph", mg, 0);
          else begin
            me = sb.pop_front();
            check(mg == me, "glyph", mg, me);
          end
        end
        pr = let_req;
        pa = let_req && let_ack;
        pg = mg;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0; instr_ptr = '0; force_redraw = 1'b0;
    wr_en2 = 1'b0; wr_idx2 = '0; wr_data2 = '0; force_redraw2 = 1'b0; let_ack2 = 1'b1;
    for (int k = 0; k < 16; k++) m_regs[k] = '0;
    m_ip = '0;
    repeat (3) @(posedge clk);
    #2;
    check(!let_req && !busy, "reset_ctrl", {let_req, busy}, 0);
    check({let_code, let_x, let_y} == 26'd0, "reset_outputs", {let_code, let_x, let_y}, 0);

    // Full redraw after release.
    for (int s = 0; s < 18; s++) push_str(s);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_idle("boot");

    // Single write, ack tied high: latency and R3 content.
    ack_mode = 1;
    @(posedge clk); #1;
    wr_en = 1'b1; wr_idx = 4'd3; wr_data = 16'hBEEF;
    m_regs[3] = 16'hBEEF;
    push_str(5);
    @(posedge clk); #1;
    wr_en = 1'b0;
    lat = 0;
    while (!let_req && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check(lat == 3, "write_latency", lat, 3);
    wait_idle("r3");

    // Ack held low: request and outputs must hold.
    ack_mode = 2;
    @(posedge clk); #1;
    wr_en = 1'b1; wr_idx = 4'd0; wr_data = 16'($urandom);
    m_regs[0] = wr_data;
    push_str(2);
    @(posedge clk); #1;
    wr_en = 1'b0;
    t = 0;
    while (!let_req && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check(let_req, "hold_req", let_req, 1);
    g0 = {let_code, let_x, let_y};
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check(let_req && ({let_code, let_x, let_y} == g0), "hold_stable",
            {let_req, let_code, let_x, let_y}, {1'b1, g0});
    end
    @(negedge clk);
    ack_mode = 1;
    @(posedge clk); #2;
    check(let_req, "pre_ack_req", let_req, 1);
    @(posedge clk); #2;
    check(!let_req, "ack_advance", let_req, 0);
    ack_mode = 0;
    wait_idle("hold");

    // Rewrite R5 while its sixth glyph is on the bus.
    @(posedge clk); #1;
    wr_en = 1'b1; wr_idx = 4'd5; wr_data = 16'hAAAA;
    m_regs[5] = 16'hAAAA;
    push_str(7);
    @(posedge clk); #1;
    wr_en = 1'b0;
    t = 0;
    while (!(let_req && let_x == 10'd485 && let_y == 10'd412) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check(t < 300, "r5_glyph5_seen", t, 0);
    wr_en = 1'b1; wr_idx = 4'd5; wr_data = 16'h1234;
    m_regs[5] = 16'h1234;
    push_str(7);
    @(posedge clk); #1;
    wr_en = 1'b0;
    wait_idle("midwrite");

    // IP change while idle redraws only S1.
    @(posedge clk); #1;
    instr_ptr = 8'h7C;
    m_ip = 8'h7C;
    push_str(1);
    wait_idle("ip");

    // Out-of-range index on a 12-register instance.
    t = 0; quiet = 0;
    while (quiet < 5 && t < 3000) begin
      @(posedge clk); #1;
      t++;
      if (!busy2 && !let_req2) quiet++;
      else quiet = 0;
    end
    check(quiet >= 5, "dut12_idle", quiet, 5);
    wr_en2 = 1'b1; wr_idx2 = 4'd13; wr_data2 = 16'($urandom);
    @(posedge clk); #1;
    wr_en2 = 1'b0;
    hi = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (let_req2 || busy2) hi++;
    end
    check(hi == 0, "oob_write_ignored", hi, 0);
    wr_en2 = 1'b1; wr_idx2 = 4'd11;
    @(posedge clk); #1;
    wr_en2 = 1'b0;
    lat = 0;
    while (!let_req2 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check(lat == 3, "inrange_write_latency", lat, 3);

    // Randomized bursts issued from idle.
    for (int it = 0; it < 30; it++) begin
      @(posedge clk); #1;
      dmask = '0;
      if ($urandom % 4 != 0) begin
        ridx = 4'($urandom % 16);
        wr_en = 1'b1; wr_idx = ridx; wr_data = 16'($urandom);
        m_regs[ridx] = wr_data;
        dmask[int'(ridx) + 2] = 1'b1;
      end
      if ($urandom % 3 == 0) begin
        nip = 8'($urandom);
        instr_ptr = nip;
        if (nip != m_ip) dmask[1] = 1'b1;
        m_ip = nip;
      end
      if ($urandom % 10 == 0) begin
        force_redraw = 1'b1;
        dmask = '1;
      end
      for (int s = 0; s < 18; s++) if (dmask[s]) push_str(s);
      @(posedge clk); #1;
      wr_en = 1'b0;
      force_redraw = 1'b0;
      wait_idle("rand");
    end

    // Reset in the middle of a forced redraw.
    @(posedge clk); #1;
    force_redraw = 1'b1;
    for (int s = 0; s < 18; s++) push_str(s);
    total = sb.size();
    @(posedge clk); #1;
    force_redraw = 1'b0;
    t = 0;
    while (sb.size() > total - 5 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    check(t < 2000, "redraw_progress", t, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check(!let_req && !busy, "async_reset_ctrl", {let_req, busy}, 0);
    check({let_code, let_x, let_y} == 26'd0, "async_reset_outputs", {let_code, let_x, let_y}, 0);
    sb.delete();
    for (int k = 0; k < 16; k++) m_regs[k] = '0;
    m_ip = instr_ptr;
    repeat (3) begin
      @(negedge clk);
      check(!let_req, "reset_quiet", let_req, 0);
    end
    for (int s = 0; s < 18; s++) push_str(s);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_idle("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
